// File: rtl/poly_tile_issuer_if.sv
// Handshake bundle between the tile issuer, its job requester and the poly_mul core.
// No storage; the issuer drives the master side, requester/core drive the slave side.
// cycles_o exists only when ISSUER_PERF_CNT_EN is defined.
interface poly_tile_issuer_if #(
  parameter int DEGREE_N  = 16,
  parameter int TILE_N    = 4,
  parameter int BIT_WIDTH = 8
);
  localparam int PW = DEGREE_N * BIT_WIDTH;
  localparam int TW = TILE_N * BIT_WIDTH;

  // job request side
  logic          req_i;
  logic [PW-1:0] c00_i;
  logic [PW-1:0] c01_i;
  logic [PW-1:0] c10_i;
  logic [PW-1:0] c11_i;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    prod_idx_o;

  // poly_mul core side
  logic [TW-1:0] as_o;
  logic [TW-1:0] bs_o;
  logic          start_o;
  logic          ready_i;
  logic          poly_mul_done_i;
  logic          rst_poly_mul_o;

`ifdef ISSUER_PERF_CNT_EN
  logic [31:0]   cycles_o;

  modport master (
    input  req_i, c00_i, c01_i, c10_i, c11_i, ready_i, poly_mul_done_i,
    output busy_o, done_o, prod_idx_o, as_o, bs_o, start_o, rst_poly_mul_o, cycles_o
  );

  modport slave (
    output req_i, c00_i, c01_i, c10_i, c11_i, ready_i, poly_mul_done_i,
    input  busy_o, done_o, prod_idx_o, as_o, bs_o, start_o, rst_poly_mul_o, cycles_o
  );
`else
  modport master (
    input  req_i, c00_i, c01_i, c10_i, c11_i, ready_i, poly_mul_done_i,
    output busy_o, done_o, prod_idx_o, as_o, bs_o, start_o, rst_poly_mul_o
  );

  modport slave (
    output req_i, c00_i, c01_i, c10_i, c11_i, ready_i, poly_mul_done_i,
    input  busy_o, done_o, prod_idx_o, as_o, bs_o, start_o, rst_poly_mul_o
  );
`endif
endinterface

// File: rtl/poly_tile_issuer.sv
// Sequences the 4 ciphertext tensor products into TILE_N x TILE_N tile issues for poly_mul_wrapper.
// Latency: first start_o 1 cycle after accept; per product T*T issues + WAIT_DONE + 2 core-reset cycles.
// Backpressure: tiles after the first of a product wait for ready_i; products wait for poly_mul_done_i.
// Optional cycle counter (cycles_o) enabled by defining ISSUER_PERF_CNT_EN.
module poly_tile_issuer #(
  parameter int DEGREE_N  = 16,
  parameter int TILE_N    = 4,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  poly_tile_issuer_if.master   bus
);
  // DEGREE_N must be a multiple of TILE_N
  localparam int T  = DEGREE_N / TILE_N;
  localparam int IW = (T > 1) ? $clog2(T) : 1;
  localparam int PW = DEGREE_N * BIT_WIDTH;
  localparam int TW = TILE_N * BIT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RDY,
    S_WAIT_DONE,
    S_RST_PM,
    S_RST_GAP,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] c00_q, c00_d;
  logic [PW-1:0] c01_q, c01_d;
  logic [PW-1:0] c10_q, c10_d;
  logic [PW-1:0] c11_q, c11_d;
  logic [IW-1:0] i_q, i_d;            // A tile index of the tile last issued / about to issue
  logic [IW-1:0] j_q, j_d;            // B tile index of the tile last issued / about to issue
  logic [1:0]    prod_q, prod_d;
  logic [TW-1:0] as_q, as_d;
  logic [TW-1:0] bs_q, bs_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          rst_pm_q, rst_pm_d;

  logic [1:0]    prod_nxt;
  logic          last_tile;

  // Extract tile idx of a polynomial; constant-index selects keep the mux shallow and width-clean.
  function automatic logic [TW-1:0] tile_of(input logic [PW-1:0] poly, input logic [IW-1:0] idx);
    logic [TW-1:0] r;
    r = '0;
    for (int k = 0; k < T; k++) begin
      if (idx == IW'(k)) r = poly[k*TW +: TW];
    end
    return r;
  endfunction

  // A operand: products 0,2 use c01, products 1,3 use c00.
  function automatic logic [PW-1:0] a_sel(input logic [1:0] p, input logic [PW-1:0] c00,
                                          input logic [PW-1:0] c01);
    return p[0] ? c00 : c01;
  endfunction

  // B operand: products 0,1 use c11, products 2,3 use c10.
  function automatic logic [PW-1:0] b_sel(input logic [1:0] p, input logic [PW-1:0] c10,
                                          input logic [PW-1:0] c11);
    return p[1] ? c10 : c11;
  endfunction

  // Next-state and registered-output computation for the tile sequencer.
  always_comb begin
    state_d   = state_q;
    c00_d     = c00_q;
    c01_d     = c01_q;
    c10_d     = c10_q;
    c11_d     = c11_q;
    i_d       = i_q;
    j_d       = j_q;
    prod_d    = prod_q;
    as_d      = as_q;
    bs_d      = bs_q;
    busy_d    = busy_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    rst_pm_d  = 1'b1;
    prod_nxt  = prod_q + 2'd1;
    last_tile = (i_q == IW'(T - 1)) && (j_q == IW'(T - 1));

    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          // Operands are captured here and never re-sampled during the job.
          c00_d   = bus.c00_i;
          c01_d   = bus.c01_i;
          c10_d   = bus.c10_i;
          c11_d   = bus.c11_i;
          i_d     = '0;
          j_d     = '0;
          prod_d  = 2'd0;
          as_d    = tile_of(bus.c01_i, '0);
          bs_d    = tile_of(bus.c11_i, '0);
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // Advance to the next (i,j) now so WAIT_RDY only has to load the operands.
        if (last_tile) begin
          state_d = S_WAIT_DONE;
        end else begin
          if (j_q == IW'(T - 1)) begin
            j_d = '0;
            i_d = i_q + IW'(1);
          end else begin
            j_d = j_q + IW'(1);
          end
          state_d = S_WAIT_RDY;
        end
      end

      S_WAIT_RDY: begin
        if (bus.ready_i) begin
          as_d    = tile_of(a_sel(prod_q, c00_q, c01_q), i_q);
          bs_d    = tile_of(b_sel(prod_q, c10_q, c11_q), j_q);
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_WAIT_DONE: begin
        if (bus.poly_mul_done_i) begin
          rst_pm_d = 1'b0;
          state_d  = S_RST_PM;
        end
      end

      S_RST_PM: begin
        // rst_pm_d defaults high: one guard cycle with the core out of reset.
        state_d = S_RST_GAP;
      end

      S_RST_GAP: begin
        if (prod_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          // First tile of the next product is issued without waiting for ready_i.
          prod_d  = prod_nxt;
          i_d     = '0;
          j_d     = '0;
          as_d    = tile_of(a_sel(prod_nxt, c00_q, c01_q), '0);
          bs_d    = tile_of(b_sel(prod_nxt, c10_q, c11_q), '0);
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_FIN: begin
        // Requests seen in this cycle are dropped: IDLE is only reached at the next edge.
        busy_d  = 1'b0;
        prod_d  = 2'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including any partial job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      c00_q    <= '0;
      c01_q    <= '0;
      c10_q    <= '0;
      c11_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      prod_q   <= 2'd0;
      as_q     <= '0;
      bs_q     <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rst_pm_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      c00_q    <= c00_d;
      c01_q    <= c01_d;
      c10_q    <= c10_d;
      c11_q    <= c11_d;
      i_q      <= i_d;
      j_q      <= j_d;
      prod_q   <= prod_d;
      as_q     <= as_d;
      bs_q     <= bs_d;
      start_q  <= start_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rst_pm_q <= rst_pm_d;
    end
  end

  assign bus.as_o           = as_q;
  assign bus.bs_o           = bs_q;
  assign bus.start_o        = start_q;
  assign bus.done_o         = done_q;
  assign bus.busy_o         = busy_q;
  assign bus.rst_poly_mul_o = rst_pm_q;
  assign bus.prod_idx_o     = prod_q;

`ifdef ISSUER_PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Job cycle count: 1 at the accept edge, +1 per edge while working, frozen in FIN and IDLE.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == S_IDLE) begin
      if (bus.req_i) cycles_d = 32'd1;
    end else if (state_q != S_FIN) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycles_q <= 32'd0;
    else      cycles_q <= cycles_d;
  end

  assign bus.cycles_o = cycles_q;
`endif
endmodule

// File: tb/tb_poly_tile_issuer.sv
// Randomized scoreboard bench for poly_tile_issuer (DEGREE_N=16, TILE_N=4).
// Driver issues jobs and plays the core; monitor pops expected tiles on every start_o.
// Expected tiles come from a tensor-product model built at job issue time.
module tb_poly_tile_issuer;
  localparam int DEGREE_N  = 16;
  localparam int TILE_N    = 4;
  localparam int BIT_WIDTH = 8;
  localparam int T         = DEGREE_N / TILE_N;
  localparam int PW        = DEGREE_N * BIT_WIDTH;
  localparam int TW        = TILE_N * BIT_WIDTH;

  typedef struct {
    logic [1:0]    p;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_tile_issuer_if #(.DEGREE_N(DEGREE_N), .TILE_N(TILE_N), .BIT_WIDTH(BIT_WIDTH)) bus ();

  poly_tile_issuer #(.DEGREE_N(DEGREE_N), .TILE_N(TILE_N), .BIT_WIDTH(BIT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks      = 0;
  int   errors      = 0;
  int   mon_starts  = 0;
  int   rst_pulses  = 0;
  int   dones       = 0;
  int   exp_starts  = 0;
  int   exp_rst     = 0;
  int   exp_dones   = 0;
  bit   prev_start  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_poly();
    logic [PW-1:0] r;
    for (int k = 0; k < PW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: four products (c01*c11, c00*c11, c01*c10, c00*c10), A tile outer, B tile inner.
  task automatic model_job(input logic [PW-1:0] c00, input logic [PW-1:0] c01,
                           input logic [PW-1:0] c10, input logic [PW-1:0] c11);
    logic [PW-1:0] a_of[4];
    logic [PW-1:0] b_of[4];
    exp_t e;
    a_of = '{c01, c00, c01, c00};
    b_of = '{c11, c11, c10, c10};
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < T; i++)
        for (int j = 0; j < T; j++) begin
          e.p = 2'(p);
          e.a = a_of[p][i*TW +: TW];
          e.b = b_of[p][j*TW +: TW];
          exp_q.push_back(e);
          exp_starts++;
        end
  endtask

  // Monitor: every start_o must match the next expected tile and be a single-cycle strobe.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.start_o) begin
        mon_starts++;
        check("start_width", 64'(prev_start), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got as=0x%0h bs=0x%0h, expected no tile", bus.as_o, bus.bs_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("tile_prod", 64'(bus.prod_idx_o), 64'(mon_e.p));
          check("tile_as", 64'(bus.as_o), 64'(mon_e.a));
          check("tile_bs", 64'(bus.bs_o), 64'(mon_e.b));
        end
      end
      if (!bus.rst_poly_mul_o) rst_pulses++;
      if (bus.done_o) dones++;
      prev_start = bus.start_o;
    end else begin
      prev_start = 1'b0;
    end
  end

  // One full job. The driver plays the core: random ready_i, done after dly cycles per product.
  task automatic run_job(input int rdy_pct, input int dly, input bit noise, input bit stall,
                         input bit remut, input bit fin_req, input bit abort);
    logic [PW-1:0] c00, c01, c10, c11;
    int seen;
    int budget;
    c00 = rand_poly();
    c01 = rand_poly();
    c10 = rand_poly();
    c11 = rand_poly();
    model_job(c00, c01, c10, c11);
    bus.c00_i = c00;
    bus.c01_i = c01;
    bus.c10_i = c10;
    bus.c11_i = c11;
    bus.req_i = 1'b1;
    tick();
    bus.req_i = 1'b0;
    seen = 0;
    if (bus.start_o) seen++;
    check("accept_start", 64'(bus.start_o), 64'd1);
    check("accept_busy", 64'(bus.busy_o), 64'd1);

    if (stall) begin
      bus.ready_i = 1'b0;
      repeat (10) begin
        tick();
        if (bus.start_o) seen++;
      end
      check("stall_hold", 64'(seen), 64'd1);
      bus.ready_i = 1'b1;
      tick();
      if (bus.start_o) seen++;
      check("stall_release", 64'(bus.start_o), 64'd1);
    end

    for (int p = 0; p < 4; p++) begin
      budget = 400;
      if (remut && p == 1) begin
        bus.c00_i = rand_poly();
        bus.req_i = 1'b1;
      end
      while (seen < (p + 1) * T * T && budget > 0) begin
        bus.ready_i         = (int'($urandom_range(99)) < rdy_pct);
        bus.poly_mul_done_i = noise ? 1'($urandom_range(1)) : 1'b0;
        tick();
        if (bus.start_o) seen++;
        budget--;
      end
      bus.req_i           = 1'b0;
      bus.poly_mul_done_i = 1'b0;
      check("tiles_per_product", 64'(seen), 64'((p + 1) * T * T));
      if (seen != (p + 1) * T * T) return;
      repeat (dly) begin
        bus.ready_i = 1'($urandom_range(1));
        tick();
      end
      if (abort && p == 2) begin
        rst = 1'b0;
        #1;
        check("abort_start", 64'(bus.start_o), 64'd0);
        check("abort_rst_pm", 64'(bus.rst_poly_mul_o), 64'd1);
        check("abort_prod", 64'(bus.prod_idx_o), 64'd0);
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        exp_starts -= exp_q.size();
        exp_q.delete();
        bus.ready_i = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        return;
      end
      bus.poly_mul_done_i = 1'b1;
      tick();
      bus.poly_mul_done_i = 1'b0;
      exp_rst++;
    end

    budget = 10;
    while (!bus.done_o && budget > 0) begin
      tick();
      budget--;
    end
    check("done_pulse", 64'(bus.done_o), 64'd1);
    check("done_busy", 64'(bus.busy_o), 64'd1);
    check("done_prod", 64'(bus.prod_idx_o), 64'd3);
    exp_dones++;
    bus.req_i = fin_req;
    tick();
    bus.req_i = 1'b0;
    check("idle_busy", 64'(bus.busy_o), 64'd0);
    check("idle_prod", 64'(bus.prod_idx_o), 64'd0);
    check("idle_done", 64'(bus.done_o), 64'd0);
    tick();
    check("fin_req_ignored", 64'(bus.start_o), 64'd0);
    bus.ready_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached with %0d tiles outstanding", exp_q.size());
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst                 = 1'b0;
    bus.req_i           = 1'b0;
    bus.c00_i           = '0;
    bus.c01_i           = '0;
    bus.c10_i           = '0;
    bus.c11_i           = '0;
    bus.ready_i         = 1'b0;
    bus.poly_mul_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) begin
      tick();
      check("reset_start", 64'(bus.start_o), 64'd0);
      check("reset_done", 64'(bus.done_o), 64'd0);
      check("reset_busy", 64'(bus.busy_o), 64'd0);
      check("reset_rst_pm", 64'(bus.rst_poly_mul_o), 64'd1);
      check("reset_prod", 64'(bus.prod_idx_o), 64'd0);
      check("reset_as", 64'(bus.as_o), 64'd0);
      check("reset_bs", 64'(bus.bs_o), 64'd0);
    end

    run_job(100, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(100, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_job(60,  2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_job(70,  3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_job(80,  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(50,  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++)
      run_job(int'($urandom_range(30, 100)), int'($urandom_range(1, 6)), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (3) tick();
    check("start_total", 64'(mon_starts), 64'(exp_starts));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("rst_pm_pulses", 64'(rst_pulses), 64'(exp_rst));
    check("done_count", 64'(dones), 64'(exp_dones));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
